// File: rtl/bot_snap_pkg.sv
// Shared field layout and snapshot type for the Rojobot snapshot FIFO.
package bot_snap_pkg;

  localparam int LOCX_MSB      = 31;
  localparam int LOCY_MSB      = 23;
  localparam int BOTINFO_MSB   = 15;
  localparam int SENSORS_MSB   = 7;
  localparam int DEPTH_DEFAULT = 4;
  localparam int SNAP_W        = 32;

  typedef struct packed {
    logic [7:0] locx;
    logic [7:0] locy;
    logic [7:0] botinfo;
    logic [7:0] sensors;
  } snapshot_t;

  // Packs the four bot registers at their fixed bit offsets.
  function automatic snapshot_t pack_snapshot(input logic [7:0] locx,
                                              input logic [7:0] locy,
                                              input logic [7:0] botinfo,
                                              input logic [7:0] sensors);
    logic [SNAP_W-1:0] w;
    w = '0;
    w[LOCX_MSB    -: 8] = locx;
    w[LOCY_MSB    -: 8] = locy;
    w[BOTINFO_MSB -: 8] = botinfo;
    w[SENSORS_MSB -: 8] = sensors;
    return snapshot_t'(w);
  endfunction

endpackage

// File: rtl/bot_snapshot_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only
// when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic                       push_ok_o,
  output logic                       valid_o,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          not_empty, do_pop, do_push;

  assign not_empty = (level_q != '0);
  assign do_pop    = pop_i & not_empty;
  assign do_push   = push_i & ((level_q != FULL_LVL) | do_pop);
  assign push_ok_o = do_push;
  assign valid_o   = not_empty;
  assign rd_data_o = not_empty ? mem_q[rd_ptr_q] : '0;
  assign level_o   = level_q;

  // Next pointer/level; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  // Storage needs no reset; empty reads are masked to zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/bot_snapshot_fifo.sv
// Captures a bot register snapshot on every upd_sysregs toggle into a FIFO,
// pulses an irq per accepted capture and counts dropped updates.
module bot_snapshot_fifo
  import bot_snap_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       upd_sysregs,
  input  logic [7:0]                 LocX,
  input  logic [7:0]                 LocY,
  input  logic [7:0]                 BotInfo,
  input  logic [7:0]                 Sensors,
  output logic                       snap_valid,
  input  logic                       snap_ready,
  output logic [31:0]                snap_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       upd_irq,
  output logic [CNT_W-1:0]           ovf_cnt,
  input  logic                       ovf_clr
);

  logic             armed_q, upd_prev_q, irq_q;
  logic             irq_d;
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             evt, push_ok;
  snapshot_t        snap_in;

  // The first edge after reset only learns the flag level, so no
  // spurious event is seen whatever level upd_sysregs resets into.
  assign evt     = armed_q & (upd_sysregs ^ upd_prev_q);
  assign snap_in = pack_snapshot(LocX, LocY, BotInfo, Sensors);

  sync_fifo #(.DEPTH(DEPTH), .W(SNAP_W)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (evt),
    .push_data_i (snap_in),
    .pop_i       (snap_ready),
    .push_ok_o   (push_ok),
    .valid_o     (snap_valid),
    .rd_data_o   (snap_data),
    .level_o     (level)
  );

  // Irq and saturating overflow counter; clear beats a same-cycle drop.
  always_comb begin
    irq_d     = evt & push_ok;
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_clr)
      ovf_cnt_d = '0;
    else if (evt && !push_ok && !(&ovf_cnt_q))
      ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  // Arming, edge history, irq pulse and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed_q    <= 1'b0;
      upd_prev_q <= 1'b0;
      irq_q      <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      armed_q    <= 1'b1;
      upd_prev_q <= upd_sysregs;
      irq_q      <= irq_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign upd_irq = irq_q;
  assign ovf_cnt = ovf_cnt_q;

endmodule
